// File: rtl/hack_boot_ctrl_if.sv
// Loader byte stream and instruction ROM write port of the Hack boot sequencer.
// master = loader/ROM side, slave = boot controller.
interface hack_boot_ctrl_if #(
    parameter int N  = 16,
    parameter int AW = 15
);
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [N-1:0]  rom_din;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, rom_we, rom_addr, rom_din
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, rom_we, rom_addr, rom_din
    );
endinterface

// File: rtl/hack_boot_ctrl.sv
// Hack CPU boot sequencer: loads a length-prefixed word image into ROM, then releases CPU reset.
// Define HACK_BOOT_CHECKSUM_EN to require a trailing sum-of-words checksum before RUN.
//
// state  | meaning
// IDLE   | after reset, CPU held, waiting for start
// HDR_HI | waiting for word-count high byte
// HDR_LO | waiting for word-count low byte
// DAT_HI | waiting for data word high byte
// DAT_LO | waiting for data word low byte, write on accept
// CHK_HI | waiting for checksum high byte (checksum build)
// CHK_LO | waiting for checksum low byte (checksum build)
// RUN    | image loaded, CPU released
// ERROR  | bad length or checksum, CPU held
module hack_boot_ctrl #(
    parameter int N  = 16,
    parameter int AW = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    hack_boot_ctrl_if.slave bus,
    output logic            cpu_rst,
    output logic            busy,
    output logic            done,
    output logic            err
);
    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] HDR_HI = 4'd1;
    localparam logic [3:0] HDR_LO = 4'd2;
    localparam logic [3:0] DAT_HI = 4'd3;
    localparam logic [3:0] DAT_LO = 4'd4;
    localparam logic [3:0] RUN    = 4'd5;
    localparam logic [3:0] ERROR  = 4'd6;
`ifdef HACK_BOOT_CHECKSUM_EN
    localparam logic [3:0] CHK_HI = 4'd7;
    localparam logic [3:0] CHK_LO = 4'd8;
    localparam logic [3:0] AFTER_DATA = CHK_HI;
`else
    localparam logic [3:0] AFTER_DATA = RUN;
`endif
    localparam logic [16:0] MAX_LEN = 17'(1) << AW;

    logic [3:0]   state, state_nxt;
    logic [AW:0]  cnt;
    logic [N-1:0] len;
    logic [7:0]   hi_q;
    logic [N-1:0] word;
    logic         accept;
    logic         last;
`ifdef HACK_BOOT_CHECKSUM_EN
    logic [N-1:0] sum;
`endif

    function automatic logic is_load(input logic [3:0] s);
        return !(s == IDLE || s == RUN || s == ERROR);
    endfunction

    assign accept = bus.byte_valid & bus.byte_ready;
    assign word   = {hi_q, bus.byte_in};
    assign last   = ({{(16-AW){1'b0}}, cnt} + 17'd1) == {1'b0, len};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RUN, ERROR: if (start) state_nxt = HDR_HI;
            HDR_HI: if (accept) state_nxt = HDR_LO;
            HDR_LO: if (accept) begin
                if ({1'b0, word} > MAX_LEN) state_nxt = ERROR;
                else if (word == '0)        state_nxt = AFTER_DATA;
                else                        state_nxt = DAT_HI;
            end
            DAT_HI: if (accept) state_nxt = DAT_LO;
            DAT_LO: if (accept) state_nxt = last ? AFTER_DATA : DAT_HI;
`ifdef HACK_BOOT_CHECKSUM_EN
            CHK_HI: if (accept) state_nxt = CHK_LO;
            CHK_LO: if (accept) state_nxt = (word == sum) ? RUN : ERROR;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            len            <= '0;
            hi_q           <= '0;
            bus.byte_ready <= 1'b0;
            bus.rom_we     <= 1'b0;
            bus.rom_addr   <= '0;
            bus.rom_din    <= '0;
            cpu_rst        <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
`ifdef HACK_BOOT_CHECKSUM_EN
            sum            <= '0;
`endif
        end else begin
            state      <= state_nxt;
            bus.rom_we <= 1'b0;
            if (!is_load(state) && start) begin
                cnt <= '0;
`ifdef HACK_BOOT_CHECKSUM_EN
                sum <= '0;
`endif
            end
            // hi_q is only consumed in the LO states, so capturing every accepted byte is harmless
            if (accept) hi_q <= bus.byte_in;
            if (accept && state == HDR_LO) len <= word;
            if (accept && state == DAT_LO) begin
                bus.rom_we   <= 1'b1;
                bus.rom_addr <= cnt[AW-1:0];
                bus.rom_din  <= word;
                cnt          <= cnt + 1'b1;
`ifdef HACK_BOOT_CHECKSUM_EN
                sum          <= sum + word;
`endif
            end
            bus.byte_ready <= is_load(state_nxt);
            busy           <= is_load(state_nxt);
            done           <= (state_nxt == RUN);
            err            <= (state_nxt == ERROR);
            // release only after a full cycle in RUN so the final ROM write lands first
            cpu_rst        <= !(state == RUN && state_nxt == RUN);
        end
    end
endmodule
